debounce_multi: RTL

- Parametrised successor to the single-button release detector.
- Synchronises, debounces and edge-detects N_CH independent push-button inputs.
- Each channel produces a clean debounced level, a one-cycle press tick and a one-cycle release tick.
- Sits between the board push-buttons and the control FSMs that consume button ticks.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_ch.sv | 193 +++++++++++++++++++
 rtl/debounce_multi.sv | 59 +++++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding and counter-width helper for debounce_multi.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package debounce_pkg;

  // Per-channel debounce FSM: stable states LOW/HIGH, qualifying states RISE/FALL.
  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  // Bits needed to hold the agreement counter up to and including stable_cnt.
  function automatic int cnt_width(input int stable_cnt);
    return (stable_cnt < 1) ? 1 : $clog2(stable_cnt + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one button channel - 2-FF synchroniser, debounce FSM, agreement counter,
// optional hold counter (DEBOUNCE_AUTOREPEAT_EN). Latency: 2 cycles sync + STABLE_CNT samples.
// Backpressure: none; ticks are single-cycle pulses with no handshake.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int REPEAT_DLY = 250,
  parameter int REPEAT_PER = 50
) (
  input  logic clkr,
  input  logic resetr,
  input  logic i_level,
  input  logic i_stb,
  output logic o_state,
  output logic o_press,
  output logic o_release
);

  localparam int CW = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          r_release;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_sync;
  logic          w_press;
  logic          w_release;
  logic          w_rep_tick;

  assign w_sync = r_s2;

  // Two-flop synchroniser for the raw asynchronous button level.
  always_ff @(posedge clkr or posedge resetr) begin
    if (resetr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_level;
      r_s2 <= r_s1;
    end
  end

  // Saturating increment: the counter can never wrap past STABLE_CNT.
  assign w_cnt_inc = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;

  // Next-state and acceptance decode; nothing moves outside strobe cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    if (i_stb) begin
      case (r_state)
        ST_LOW: begin
          if (w_sync) begin
            if (STABLE_CNT == 1) begin
              w_state_nxt = ST_HIGH;
              w_cnt_nxt   = '0;
              w_press     = 1'b1;
            end else begin
              w_state_nxt = ST_RISE;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        ST_RISE: begin
          if (w_sync) begin
            if (w_cnt_inc == CNT_MAX) begin
              w_state_nxt = ST_HIGH;
              w_cnt_nxt   = '0;
              w_press     = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
          end
        end
        ST_HIGH: begin
          if (!w_sync) begin
            if (STABLE_CNT == 1) begin
              w_state_nxt = ST_LOW;
              w_cnt_nxt   = '0;
              w_release   = 1'b1;
            end else begin
              w_state_nxt = ST_FALL;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        ST_FALL: begin
          if (!w_sync) begin
            if (w_cnt_inc == CNT_MAX) begin
              w_state_nxt = ST_LOW;
              w_cnt_nxt   = '0;
              w_release   = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state, agreement counter and registered tick outputs.
  always_ff @(posedge clkr or posedge resetr) begin
    if (resetr) begin
      r_state   <= ST_LOW;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press | w_rep_tick;
      r_release <= w_release;
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  logic [HW-1:0] r_hold;
  logic          r_rep_phase;
  logic [HW-1:0] w_hold_nxt;
  logic [HW-1:0] w_hold_inc;
  logic [HW-1:0] w_hold_lim;
  logic          w_phase_nxt;

  // First repeat waits REPEAT_DLY strobes, later ones REPEAT_PER.
  assign w_hold_lim = r_rep_phase ? HW'(REPEAT_PER) : HW'(REPEAT_DLY);
  assign w_hold_inc = r_hold + HW'(1);

  // Hold counting only while the channel stays in HIGH; any exit clears it.
  always_comb begin
    w_hold_nxt  = r_hold;
    w_phase_nxt = r_rep_phase;
    w_rep_tick  = 1'b0;
    if ((r_state != ST_HIGH) || (w_state_nxt != ST_HIGH)) begin
      w_hold_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (i_stb) begin
      if (w_hold_inc == w_hold_lim) begin
        w_rep_tick  = 1'b1;
        w_hold_nxt  = '0;
        w_phase_nxt = 1'b1;
      end else begin
        w_hold_nxt = w_hold_inc;
      end
    end
  end

  // Hold counter and repeat-phase registers.
  always_ff @(posedge clkr or posedge resetr) begin
    if (resetr) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else begin
      r_hold      <= w_hold_nxt;
      r_rep_phase <= w_phase_nxt;
    end
  end
`else
  logic w_rep_cfg_unused;

  assign w_rep_tick       = 1'b0;
  assign w_rep_cfg_unused = REPEAT_DLY[0] ^ REPEAT_PER[0];
`endif

  assign o_state   = (r_state == ST_HIGH) || (r_state == ST_FALL);
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N_CH push-button debouncer with shared sample prescaler (auto-repeat via DEBOUNCE_AUTOREPEAT_EN).
// Latency: 2 sync cycles plus STABLE_CNT sample strobes to an accepted level and tick.
// Backpressure: none; outputs are levels and one-cycle pulses.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int SAMPLE_DIV = 1000,
  parameter int STABLE_CNT = 4,
  parameter int REPEAT_DLY = 250,
  parameter int REPEAT_PER = 50
) (
  input  logic            clkr,
  input  logic            resetr,
  input  logic [N_CH-1:0] levelr,
  output logic [N_CH-1:0] stater,
  output logic [N_CH-1:0] press_tickr,
  output logic [N_CH-1:0] release_tickr,
  output logic            sample_stbr
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0] r_div;
  logic          w_stb;

  // Free-running prescaler 0..SAMPLE_DIV-1 shared by all channels.
  always_ff @(posedge clkr or posedge resetr) begin
    if (resetr) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Strobe is held low in reset so a SAMPLE_DIV of 1 still reads 0 while reset.
  assign w_stb       = (r_div == DIV_LAST) && !resetr;
  assign sample_stbr = w_stb;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
    ) u_ch (
      .clkr      (clkr),
      .resetr    (resetr),
      .i_level   (levelr[g]),
      .i_stb     (w_stb),
      .o_state   (stater[g]),
      .o_press   (press_tickr[g]),
      .o_release (release_tickr[g])
    );
  end

endmodule
